// File: rtl/xnor_lfsr_descrambler.sv
// -----------------------------------------------------------------------------
// xnor_lfsr_descrambler
//   Self-synchronizing descrambler for an XNOR-feedback LFSR scrambled link.
//   Each accepted WIDTH-bit word is descrambled in one cycle, with bit 0 being
//   the oldest bit on the line. The shift register is loaded with the received
//   (scrambled) bits, so it re-aligns to the transmitter after LFSR_LEN bits.
//   out_sync marks words whose first bit saw a fully primed register.
//
//   Optional feature: define XNOR_DESCR_BYPASS_EN to add the 'bypass' input.
//   When that input is high, an accepted word passes through unchanged, but the
//   LFSR and the fill tracking still advance.
//
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   flush              synchronous clear: LFSR, output stage and fill state
//   bypass             (XNOR_DESCR_BYPASS_EN only) pass word through unchanged
//   in_valid/in_ready  scrambled word handshake (in_data)
//   out_valid/out_ready descrambled word handshake (out_data, out_sync)
// -----------------------------------------------------------------------------

// One descrambled bit: data = XNOR of received bit with the two taps.
module xnor_descr_lane (
   input  logic c,
   input  logic tap_a,
   input  logic tap_b,
   output logic d
);
   assign d = ~(c ^ tap_a ^ tap_b);
endmodule

module xnor_lfsr_descrambler #(
   parameter int WIDTH    = 8,
   parameter int LFSR_LEN = 7,
   parameter int TAP_A    = 7,
   parameter int TAP_B    = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
`ifdef XNOR_DESCR_BYPASS_EN
   input  logic             bypass,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sync
);

   localparam int FILL_WORDS = (LFSR_LEN + WIDTH - 1) / WIDTH;
   localparam int CNT_W      = (FILL_WORDS < 2) ? 1 : $clog2(FILL_WORDS + 1);

   typedef enum logic [0:0] {FILL = 1'b0, LOCKED = 1'b1} state_t;

   state_t              state;
   logic [CNT_W-1:0]    fill_cnt;
   logic [LFSR_LEN-1:0] s;
   logic [LFSR_LEN-1:0] s_next;
   logic [WIDTH-1:0]    tap_a_v, tap_b_v, desc;
   logic [WIDTH-1:0]    word_out;
   logic                accept;

   // Bit k sees the register after k shifts. Position i of that register
   // holds in_data[k-1-i] if it was shifted in during this word (i < k),
   // otherwise the old s[i-k]. Resolving taps this way avoids a serial chain.
   for (genvar k = 0; k < WIDTH; k++) begin : g_lane
      if (TAP_A - 1 < k) begin : g_ta_in
         assign tap_a_v[k] = in_data[k-TAP_A];
      end else begin : g_ta_s
         assign tap_a_v[k] = s[TAP_A-1-k];
      end
      if (TAP_B - 1 < k) begin : g_tb_in
         assign tap_b_v[k] = in_data[k-TAP_B];
      end else begin : g_tb_s
         assign tap_b_v[k] = s[TAP_B-1-k];
      end
      xnor_descr_lane u_lane (
         .c     (in_data[k]),
         .tap_a (tap_a_v[k]),
         .tap_b (tap_b_v[k]),
         .d     (desc[k])
      );
   end

   // Register contents after all WIDTH shifts (s[0] newest).
   for (genvar i = 0; i < LFSR_LEN; i++) begin : g_snext
      if (i < WIDTH) begin : g_from_in
         assign s_next[i] = in_data[WIDTH-1-i];
      end else begin : g_from_s
         assign s_next[i] = s[i-WIDTH];
      end
   end

`ifdef XNOR_DESCR_BYPASS_EN
   assign word_out = bypass ? in_data : desc;
`else
   assign word_out = desc;
`endif

   assign in_ready = ~flush & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s         <= '0;
         state     <= FILL;
         fill_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sync  <= 1'b0;
      end else if (flush) begin
         s         <= '0;
         state     <= FILL;
         fill_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sync  <= 1'b0;
      end else if (accept) begin
         s         <= s_next;
         out_valid <= 1'b1;
         out_data  <= word_out;
         // Sync reflects the state before this word updates it.
         out_sync  <= (state == LOCKED);
         if (fill_cnt != CNT_W'(FILL_WORDS))
            fill_cnt <= fill_cnt + CNT_W'(1);
         if (state == FILL && fill_cnt == CNT_W'(FILL_WORDS - 1))
            state <= LOCKED;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_xnor_lfsr_descrambler.sv
module tb_xnor_lfsr_descrambler;
   localparam int W = 8, L = 7, TA = 7, TB = 6;
   localparam int FW = (L + W - 1) / W;

   logic         clk = 1'b0;
   logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_sync, bypass;
   logic [W-1:0] in_data, out_data;

   always #5 clk = ~clk;

   xnor_lfsr_descrambler #(.WIDTH(W), .LFSR_LEN(L), .TAP_A(TA), .TAP_B(TB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
`ifdef XNOR_DESCR_BYPASS_EN
      .bypass    (bypass),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sync  (out_sync)
   );

   typedef struct {logic [W-1:0] d; logic s;} exp_t;
   typedef struct {logic rst; logic [W-1:0] din; logic [W-1:0] dexp; logic sexp;} vec_t;

   exp_t         sb[$];
   exp_t         nxt;
   bit           acc_f;
   bit           rnd_rdy = 0;
   int           total = 0, bad = 0;
   logic [L-1:0] m_s;
   int           m_cnt;
   bit           m_lock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s", nm);
   endtask

   // Bit-serial reference descrambler.
   function automatic logic [W-1:0] mdl_d(input logic [W-1:0] c, input logic byp,
                                          input logic [L-1:0] s0);
      logic [L-1:0] sv;
      logic [W-1:0] d;
      sv = s0;
      for (int k = 0; k < W; k++) begin
         d[k] = byp ? c[k] : ~(c[k] ^ sv[TA-1] ^ sv[TB-1]);
         sv = {sv[L-2:0], c[k]};
      end
      return d;
   endfunction

   function automatic logic [L-1:0] mdl_snext(input logic [W-1:0] c, input logic [L-1:0] s0);
      logic [L-1:0] sv;
      sv = s0;
      for (int k = 0; k < W; k++) sv = {sv[L-2:0], c[k]};
      return sv;
   endfunction

   task automatic mdl_commit(input logic [W-1:0] c);
      m_s = mdl_snext(c, m_s);
      if (!m_lock) begin
         m_cnt++;
         if (m_cnt >= FW) m_lock = 1;
      end
   endtask

   task automatic mdl_reset();
      m_s = '0; m_cnt = 0; m_lock = 0;
      sb.delete();
   endtask

   // One clock: sample handshakes at negedge+1, score, advance to next negedge.
   task automatic cyc();
      exp_t e;
      #1;
      acc_f = 0;
      if (flush) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) fail("unexpected_output");
            else begin
               e = sb.pop_front();
               chk("out_data", out_data, e.d);
               chk("out_sync", out_sync, e.s);
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back(nxt);
            acc_f = 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_exp(input logic [W-1:0] d, input logic [W-1:0] ed, input logic es,
                           input logic byp, output int tries);
      nxt.d = ed; nxt.s = es;
      in_data = d; bypass = byp; in_valid = 1; tries = 0;
      do begin
         if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
         cyc();
         tries++;
      end while (!acc_f && tries < 20);
      if (!acc_f) fail("accept_timeout");
      in_valid = 0; bypass = 0;
   endtask

   task automatic send_mdl(input logic [W-1:0] d, input logic byp);
      int t;
      send_exp(d, mdl_d(d, byp, m_s), m_lock, byp, t);
      if (acc_f) mdl_commit(d);
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 0; out_ready = 1; rnd_rdy = 0;
      while (sb.size() != 0 && n < 10) begin cyc(); n++; end
      if (sb.size() != 0) fail("drain_timeout");
      #1 chk("idle_out_valid", out_valid, 0);
   endtask

   task automatic do_reset();
      rst_n = 0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sync", out_sync, 0);
      mdl_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      #200000;
      fail("global_timeout");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      vec_t         tbl[5];
      logic [W-1:0] orig[64], scr[64];
      logic [L-1:0] sc_s;
      logic [W-1:0] held;
      int           t, cyc_after;

      flush = 0; in_valid = 0; out_ready = 1; bypass = 0; in_data = '0; rst_n = 0;
      @(negedge clk);
      do_reset();

      // Directed vectors; rst=1 means reset before that entry.
      tbl[0] = '{1'b1, 8'h00, 8'hFF, 1'b0};
      tbl[1] = '{1'b0, 8'h00, 8'hFF, 1'b1};
      tbl[2] = '{1'b1, 8'hFF, 8'h40, 1'b0};
      tbl[3] = '{1'b0, 8'hFF, 8'h00, 1'b1};
      tbl[4] = '{1'b0, 8'h00, 8'hBF, 1'b1};
      for (int i = 0; i < 5; i++) begin
         if (tbl[i].rst) begin drain(); do_reset(); end
         send_exp(tbl[i].din, tbl[i].dexp, tbl[i].sexp, 1'b0, t);
         chk("tbl_latency", t, 1);
      end
      drain();

      // Random stream through a reference XNOR scrambler; stall mid-stream.
      do_reset();
      sc_s = 7'h5A;
      for (int i = 0; i < 64; i++) begin
         orig[i] = W'($urandom);
         for (int k = 0; k < W; k++) begin
            scr[i][k] = ~(orig[i][k] ^ sc_s[TA-1] ^ sc_s[TB-1]);
            sc_s = {sc_s[L-2:0], scr[i][k]};
         end
      end
      cyc_after = 0;
      for (int i = 0; i < 64; i++) begin
         if (i == 20) begin
            in_data = scr[i]; in_valid = 1; out_ready = 0;
            #1 held = out_data;
            chk("stall_valid", out_valid, 1);
            @(negedge clk);
            for (int j = 0; j < 5; j++) begin
               #1;
               chk("stall_in_ready", in_ready, 0);
               chk("stall_out_valid", out_valid, 1);
               chk("stall_out_data", out_data, held);
               @(negedge clk);
            end
            out_ready = 1;
         end
         if (i == 0) send_exp(scr[i], mdl_d(scr[i], 1'b0, m_s), 1'b0, 1'b0, t);
         else        send_exp(scr[i], orig[i], 1'b1, 1'b0, t);
         if (acc_f) mdl_commit(scr[i]);
         if (i >= 20) cyc_after += t;
      end
      chk("resume_rate", cyc_after, 44);
      drain();

      // Random backpressure.
      rnd_rdy = 1;
      for (int i = 0; i < 30; i++) send_mdl(W'($urandom), 1'b0);
      drain();

      // Flush with a pending output word, then rerun the directed pair.
      out_ready = 0;
      send_mdl(8'h00, 1'b0);
      flush = 1;
      #1 chk("flush_in_ready", in_ready, 0);
      cyc();
      flush = 0;
      mdl_reset();
      #1 chk("flush_out_valid", out_valid, 0);
      out_ready = 1;
      send_exp(8'hFF, 8'h40, 1'b0, 1'b0, t); mdl_commit(8'hFF);
      send_exp(8'hFF, 8'h00, 1'b1, 1'b0, t); mdl_commit(8'hFF);
      drain();

      // Reset with a held output word.
      out_ready = 0;
      send_mdl(8'h00, 1'b0);
      #1 chk("pre_rst_valid", out_valid, 1);
      do_reset();
      out_ready = 1;

`ifdef XNOR_DESCR_BYPASS_EN
      send_mdl(8'h00, 1'b0);
      send_exp(8'hA5, 8'hA5, 1'b1, 1'b1, t); mdl_commit(8'hA5);
      send_mdl(8'h3C, 1'b0);
      send_mdl(8'hC3, 1'b0);
      drain();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
